// File: rtl/text_stream_pkg.sv
// Shared types and helpers for the text stream reader: FSM states, NUL character, count widths.
package text_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } ts_state_e;

  localparam logic [7:0] NUL_CHAR = 8'h00;

  // Width able to hold the values 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/text_stream_reader_if.sv
// Character output stream of the text stream reader (valid/ready, producer is master).
interface text_stream_reader_if #(
  parameter int DW = 8
) ();

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/text_stream_fifo.sv
// Synchronous DW x DEPTH FIFO with occupancy count and same-cycle push/pop; head is combinational.
module text_stream_fifo
  import text_stream_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int CW   = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  // Storage is not reset, so an empty FIFO presents zero rather than stale contents.
  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/text_stream_reader.sv
// Streams a string from a synchronous text ROM onto a valid/ready character output.
// Optional: define TEXT_STREAM_NUL_STOP_EN to end a string early at a returned 0 character.
module text_stream_reader
  import text_stream_pkg::*;
#(
  parameter int AW         = 11,
  parameter int LW         = 11,
  parameter int DW         = 8,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [LW-1:0]        start_len,
  output logic                 busy,
  output logic                 done,
  output logic                 rom_en,
  output logic [AW-1:0]        rom_addr,
  input  logic [DW-1:0]        rom_data,
  text_stream_reader_if.master out_if
);

  localparam int CW = count_width(FIFO_DEPTH);

  ts_state_e     state;
  ts_state_e     state_nxt;
  logic [AW-1:0] addr;
  logic [LW-1:0] remaining;
  logic [ROM_LAT-1:0] tag;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          arrive;
  logic          nul_hit;
  logic          push;
  logic          pop;

  assign arrive = tag[ROM_LAT-1];

`ifdef TEXT_STREAM_NUL_STOP_EN
  assign nul_hit = arrive && (rom_data == DW'(NUL_CHAR));
`else
  assign nul_hit = 1'b0;
`endif

  assign push             = arrive && !nul_hit;
  assign out_if.out_valid = !fifo_empty;
  assign pop              = out_if.out_valid && out_if.out_ready;
  assign busy             = (state != IDLE);
  assign rom_addr         = addr;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ROM_LAT; i++) inflight = inflight + CW'(tag[i]);
  end

  always_comb begin
    state_nxt = state;
    rom_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (start_len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        // Reads in flight plus buffered characters must always fit in the FIFO.
        rom_en = (remaining != '0) && !nul_hit &&
                 (({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
        if (nul_hit || remaining == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0 && fifo_empty) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      tag       <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      if (state == IDLE && start) begin
        addr      <= start_addr;
        remaining <= start_len;
      end else if (rom_en) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (nul_hit) begin
        remaining <= '0;
        tag       <= '0;
      end else begin
        tag <= ROM_LAT'({tag, rom_en});
      end
    end
  end

  text_stream_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rom_data),
    .pop       (pop),
    .head_data (out_if.out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
